// File: rtl/alpha68k_pkg.sv
// Shared definitions for the alpha68k board interrupt logic.
//   IPL_NONE / IPL_VBL / IPL_MCU : default 68000 autovector levels
//   wd_state_t                   : watchdog FSM state encoding (WD_RUN, WD_FIRE)
package alpha68k_pkg;

  localparam logic [2:0] IPL_NONE = 3'd0;
  localparam logic [2:0] IPL_VBL  = 3'd1;
  localparam logic [2:0] IPL_MCU  = 3'd2;

  typedef enum logic {
    WD_RUN  = 1'b0,
    WD_FIRE = 1'b1
  } wd_state_t;

endpackage

// File: rtl/m68k_irq_ctrl_rise_edge.sv
// Rising-edge detector: pulse is high for the one cycle in which d is high
// and was low in the previous cycle.
//   clk   in  system clock
//   reset in  asynchronous active-high reset (history cleared to 0)
//   d     in  level to watch, synchronous to clk
//   pulse out single-cycle rising-edge indication (combinational)
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_prev <= 1'b0;
    else       d_prev <= d;
  end

  assign pulse = d & ~d_prev;

endmodule

// File: rtl/m68k_irq_ctrl.sv
// 68000 interrupt controller for the alpha68k board.
// Latches vblank and MCU interrupt requests, presents the highest pending
// level as an active-low autovector IPL, and runs a frame-counted watchdog
// that emits a fixed-width CPU reset pulse.
//   clk, reset        clock and asynchronous active-high reset
//   vbl, mcu_irq      interrupt request levels (edge-triggered)
//   vbl_int_clr_cs    clears the vblank pending flag on its rising edge
//   cpu_int_clr_cs    clears the MCU pending flag on its rising edge
//   watchdog_clr_cs   refreshes the watchdog on its rising edge
//   m68k_ipl_n        active-low IPL to the CPU
//   vbl_pending       vblank interrupt pending
//   mcu_pending       MCU interrupt pending
//   wd_reset          watchdog reset pulse, WD_RST_CYC cycles wide
module m68k_irq_ctrl
  import alpha68k_pkg::*;
#(
  parameter logic [2:0] VBL_LEVEL  = IPL_VBL,
  parameter logic [2:0] MCU_LEVEL  = IPL_MCU,
  parameter int         WD_FRAMES  = 8,
  parameter int         WD_RST_CYC = 64,
  parameter bit         WD_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vbl,
  input  logic       mcu_irq,
  input  logic       vbl_int_clr_cs,
  input  logic       cpu_int_clr_cs,
  input  logic       watchdog_clr_cs,
  output logic [2:0] m68k_ipl_n,
  output logic       vbl_pending,
  output logic       mcu_pending,
  output logic       wd_reset
);

  localparam logic [2:0] BOTH_LEVEL = (VBL_LEVEL > MCU_LEVEL) ? VBL_LEVEL : MCU_LEVEL;
  localparam logic [8:0] FRAMES_LIM = 9'(WD_FRAMES);
  localparam logic [9:0] PULSE_LOAD = 10'(WD_RST_CYC - 1);

  logic vbl_edge, mcu_edge, vbl_clr_edge, mcu_clr_edge, wd_clr_edge;

  rise_edge u_vbl_edge     (.clk(clk), .reset(reset), .d(vbl),             .pulse(vbl_edge));
  rise_edge u_mcu_edge     (.clk(clk), .reset(reset), .d(mcu_irq),         .pulse(mcu_edge));
  rise_edge u_vbl_clr_edge (.clk(clk), .reset(reset), .d(vbl_int_clr_cs),  .pulse(vbl_clr_edge));
  rise_edge u_mcu_clr_edge (.clk(clk), .reset(reset), .d(cpu_int_clr_cs),  .pulse(mcu_clr_edge));
  rise_edge u_wd_clr_edge  (.clk(clk), .reset(reset), .d(watchdog_clr_cs), .pulse(wd_clr_edge));

  // Set has priority over clear so a request arriving in the same cycle as
  // the software acknowledge is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbl_pending <= 1'b0;
      mcu_pending <= 1'b0;
    end else begin
      if (vbl_edge)          vbl_pending <= 1'b1;
      else if (vbl_clr_edge) vbl_pending <= 1'b0;
      if (mcu_edge)          mcu_pending <= 1'b1;
      else if (mcu_clr_edge) mcu_pending <= 1'b0;
    end
  end

  logic [2:0] level;

  always_comb begin
    level = IPL_NONE;
    if (vbl_pending && mcu_pending) level = BOTH_LEVEL;
    else if (vbl_pending)           level = VBL_LEVEL;
    else if (mcu_pending)           level = MCU_LEVEL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) m68k_ipl_n <= 3'b111;
    else       m68k_ipl_n <= ~level;
  end

  wd_state_t  state, state_next;
  logic [7:0] frame_cnt, frame_next;
  logic [9:0] pulse_cnt, pulse_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WD_RUN;
      frame_cnt <= 8'd0;
      pulse_cnt <= 10'd0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_next;
      pulse_cnt <= pulse_next;
    end
  end

  // Refresh beats a coincident vblank edge. When disabled the frame counter
  // still runs but saturates at 255 instead of firing.
  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    pulse_next = pulse_cnt;
    case (state)
      WD_RUN: begin
        if (wd_clr_edge) begin
          frame_next = 8'd0;
        end else if (vbl_edge) begin
          if (WD_EN && ({1'b0, frame_cnt} + 9'd1 >= FRAMES_LIM)) begin
            state_next = WD_FIRE;
            pulse_next = PULSE_LOAD;
            frame_next = 8'd0;
          end else if (frame_cnt != 8'hFF) begin
            frame_next = frame_cnt + 8'd1;
          end
        end
      end
      WD_FIRE: begin
        if (pulse_cnt == 10'd0) state_next = WD_RUN;
        else                    pulse_next = pulse_cnt - 10'd1;
      end
      default: state_next = WD_RUN;
    endcase
  end

  assign wd_reset = (state == WD_FIRE);

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Directed self-checking bench for m68k_irq_ctrl with default parameters.
// Inputs change 1ns after a rising clock edge; outputs are sampled there too,
// so each sample reflects the registers updated by that edge.
module tb_m68k_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       vbl, mcu_irq, vbl_int_clr_cs, cpu_int_clr_cs, watchdog_clr_cs;
  logic [2:0] m68k_ipl_n;
  logic       vbl_pending, mcu_pending, wd_reset;

  int checks   = 0;
  int failures = 0;
  logic wd_seen;
  int   pulse_len;

  m68k_irq_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .vbl             (vbl),
    .mcu_irq         (mcu_irq),
    .vbl_int_clr_cs  (vbl_int_clr_cs),
    .cpu_int_clr_cs  (cpu_int_clr_cs),
    .watchdog_clr_cs (watchdog_clr_cs),
    .m68k_ipl_n      (m68k_ipl_n),
    .vbl_pending     (vbl_pending),
    .mcu_pending     (mcu_pending),
    .wd_reset        (wd_reset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    wd_seen = wd_seen | wd_reset;
  endtask

  task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic vbl_edge_pulse();
    vbl = 1'b1;
    step();
    vbl = 1'b0;
    step();
  endtask

  task automatic refresh();
    watchdog_clr_cs = 1'b1;
    step();
    watchdog_clr_cs = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    vbl = 1'b0; mcu_irq = 1'b0;
    vbl_int_clr_cs = 1'b0; cpu_int_clr_cs = 1'b0; watchdog_clr_cs = 1'b0;
    wd_seen = 1'b0;
    pulse_len = 0;

    // 1. reset state
    step(); step();
    reset = 1'b0;
    step();
    check("rst_ipl", 10'(m68k_ipl_n), 10'h7);
    check("rst_wd", 10'(wd_reset), 10'h0);
    check("rst_vblp", 10'(vbl_pending), 10'h0);
    check("rst_mcup", 10'(mcu_pending), 10'h0);

    // 2. vbl held high, then a held clear select
    $display("[TB] vblank set/clear");
    vbl = 1'b1;
    step();
    check("vbl_set_pend", 10'(vbl_pending), 10'h1);
    check("vbl_set_ipl_lag", 10'(m68k_ipl_n), 10'h7);
    step();
    check("vbl_set_ipl", 10'(m68k_ipl_n), 10'h6);
    repeat (98) step();
    check("vbl_hold_pend", 10'(vbl_pending), 10'h1);
    vbl_int_clr_cs = 1'b1;
    step();
    check("vbl_clr_pend", 10'(vbl_pending), 10'h0);
    check("vbl_clr_ipl_lag", 10'(m68k_ipl_n), 10'h6);
    step();
    check("vbl_clr_ipl", 10'(m68k_ipl_n), 10'h7);
    step(); step();
    check("vbl_clr_hold_pend", 10'(vbl_pending), 10'h0);
    vbl_int_clr_cs = 1'b0; vbl = 1'b0;
    step();

    // 3. both pending, then clear one at a time
    $display("[TB] priority");
    vbl = 1'b1; mcu_irq = 1'b1;
    step();
    check("both_vblp", 10'(vbl_pending), 10'h1);
    check("both_mcup", 10'(mcu_pending), 10'h1);
    step();
    check("both_ipl", 10'(m68k_ipl_n), 10'h5);
    cpu_int_clr_cs = 1'b1;
    step();
    check("mcu_clr_pend", 10'(mcu_pending), 10'h0);
    step();
    check("mcu_clr_ipl", 10'(m68k_ipl_n), 10'h6);
    cpu_int_clr_cs = 1'b0;
    vbl_int_clr_cs = 1'b1;
    step(); step();
    check("all_clr_ipl", 10'(m68k_ipl_n), 10'h7);
    check("all_clr_vblp", 10'(vbl_pending), 10'h0);
    vbl_int_clr_cs = 1'b0; vbl = 1'b0; mcu_irq = 1'b0;
    step();

    // mcu alone
    mcu_irq = 1'b1;
    step(); step();
    check("mcu_only_ipl", 10'(m68k_ipl_n), 10'h5);
    mcu_irq = 1'b0; cpu_int_clr_cs = 1'b1;
    step(); step();
    check("mcu_only_clr_ipl", 10'(m68k_ipl_n), 10'h7);
    cpu_int_clr_cs = 1'b0;
    step();

    // 4. set and clear edges in the same cycle
    $display("[TB] set beats clear");
    vbl = 1'b1; vbl_int_clr_cs = 1'b1;
    step();
    check("setclr_pend", 10'(vbl_pending), 10'h1);
    step();
    check("setclr_ipl", 10'(m68k_ipl_n), 10'h6);
    vbl = 1'b0; vbl_int_clr_cs = 1'b0;
    step();
    vbl_int_clr_cs = 1'b1;
    step();
    check("setclr_after_clr", 10'(vbl_pending), 10'h0);
    vbl_int_clr_cs = 1'b0;
    step();

    // 5. watchdog fires after 8 unrefreshed frames, pulse 64 cycles
    $display("[TB] watchdog fire");
    refresh();
    wd_seen = 1'b0;
    for (int i = 0; i < 7; i++) vbl_edge_pulse();
    check("wd_7_edges", 10'(wd_seen), 10'h0);
    vbl = 1'b1;
    step();
    check("wd_fire", 10'(wd_reset), 10'h1);
    vbl = 1'b0;
    pulse_len = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (wd_reset) pulse_len++;
      else break;
    end
    check("wd_pulse_len", 10'(pulse_len), 10'd64);
    check("wd_pulse_end", 10'(wd_reset), 10'h0);

    // refresh in the middle prevents firing
    wd_seen = 1'b0;
    for (int i = 0; i < 7; i++) vbl_edge_pulse();
    refresh();
    for (int i = 0; i < 7; i++) vbl_edge_pulse();
    check("wd_refreshed", 10'(wd_seen), 10'h0);

    // 6. reset truncates the pulse; counter restarts from zero
    $display("[TB] reset during pulse");
    refresh();
    for (int i = 0; i < 8; i++) vbl_edge_pulse();
    repeat (8) step();
    check("wd_mid_pulse", 10'(wd_reset), 10'h1);
    vbl = 1'b1;
    step();
    vbl = 1'b0;
    check("wd_mid_pend", 10'(vbl_pending), 10'h1);
    reset = 1'b1;
    #1;
    check("rst_async_wd", 10'(wd_reset), 10'h0);
    check("rst_async_pend", 10'(vbl_pending), 10'h0);
    check("rst_async_ipl", 10'(m68k_ipl_n), 10'h7);
    step();
    reset = 1'b0;
    step();
    wd_seen = 1'b0;
    for (int i = 0; i < 7; i++) vbl_edge_pulse();
    check("wd_after_rst_7", 10'(wd_seen), 10'h0);
    vbl = 1'b1;
    step();
    check("wd_after_rst_8", 10'(wd_reset), 10'h1);
    vbl = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
